// File: rtl/conv_stream_tx_pkg.sv
// Shared constants for the convolution output path: word packing, convolver latency,
// output buffering and frame size, plus width helpers used by conv_stream_tx.
package conv_stream_tx_pkg;

    localparam int DFLT_NB_PIXEL         = 8;
    localparam int DFLT_PIXELS_PER_WORD  = 4;
    localparam int DFLT_NB_DATA          = DFLT_NB_PIXEL * DFLT_PIXELS_PER_WORD;
    localparam int DFLT_CONV_LATENCY     = 4;
    localparam int DFLT_FIFO_DEPTH       = 16;
    localparam int DFLT_WORDS_PER_FRAME  = 9800;

    // Occupancy needs one extra bit so a completely full buffer is representable.
    function automatic int fill_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int cnt_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/conv_stream_tx_sync_fifo.sv
// First-word-fall-through FIFO: the head entry is always visible on dout while not empty.
// Pointers carry one extra MSB so full and empty are distinguished without a separate counter.
module conv_stream_tx_sync_fifo
    import conv_stream_tx_pkg::*;
#(
    parameter int NB_DATA = DFLT_NB_DATA,
    parameter int DEPTH   = DFLT_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     write,
    input  logic [NB_DATA-1:0]       din,
    input  logic                     read,
    output logic [NB_DATA-1:0]       dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [NB_DATA-1:0] mem [DEPTH];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic               wr_en;
    logic               rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

    // A write into a full buffer is accepted only when the head leaves in the same cycle.
    assign rd_en = read & ~empty;
    assign wr_en = write & (~full | rd_en);

    assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/conv_stream_tx.sv
// AXI-Stream transmitter for packed convolution results: realigns the input valid to the
// convolver latency, buffers words against backpressure, marks frame ends and flags drops.
module conv_stream_tx
    import conv_stream_tx_pkg::*;
#(
    parameter int NB_DATA         = DFLT_NB_DATA,
    parameter int CONV_LATENCY    = DFLT_CONV_LATENCY,
    parameter int FIFO_DEPTH      = DFLT_FIFO_DEPTH,
    parameter int WORDS_PER_FRAME = DFLT_WORDS_PER_FRAME
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_valid,
    input  logic [NB_DATA-1:0]            i_data,
    output logic [NB_DATA-1:0]            m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          o_overflow,
    output logic                          o_frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   o_fill
);

    localparam int              NB_CNT   = cnt_width(WORDS_PER_FRAME);
    localparam logic [NB_CNT-1:0] LAST_IDX = NB_CNT'(WORDS_PER_FRAME - 1);

    logic               d_valid;
    logic               fifo_full;
    logic               fifo_empty;
    logic               rd;
    logic               at_last;
    logic [NB_DATA-1:0] head;
    logic [NB_CNT-1:0]  frame_cnt;

    // Stage boundary: i_valid delayed to line up with the convolver result on i_data.
    generate
        if (CONV_LATENCY == 0) begin : g_no_delay
            assign d_valid = i_valid;
        end else begin : g_delay
            logic [CONV_LATENCY-1:0] vld_p;

            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) vld_p <= '0;
                else         vld_p <= (vld_p << 1) | CONV_LATENCY'(i_valid);
            end

            assign d_valid = vld_p[CONV_LATENCY-1];
        end
    endgenerate

    // Stage boundary: aligned words enter the output buffer.
    conv_stream_tx_sync_fifo #(
        .NB_DATA (NB_DATA),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .reset (i_reset),
        .write (d_valid),
        .din   (i_data),
        .read  (rd),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (o_fill)
    );

    assign m_axis_tvalid = ~fifo_empty;
    assign m_axis_tdata  = head;
    assign rd            = m_axis_tvalid & m_axis_tready;
    assign at_last       = (frame_cnt == LAST_IDX);
    assign m_axis_tlast  = m_axis_tvalid & at_last;

    // Only completed handshakes advance the frame position, so dropped words shift framing.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            frame_cnt    <= '0;
            o_frame_done <= 1'b0;
            o_overflow   <= 1'b0;
        end else begin
            o_frame_done <= rd & at_last;
            if (rd) frame_cnt <= at_last ? '0 : frame_cnt + NB_CNT'(1);
            if (d_valid & fifo_full & ~rd) o_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_conv_stream_tx.sv
// Directed bench for conv_stream_tx: a queue-based reference of the stream checked every cycle,
// plus literal expectations for latency, fill, overflow and framing.
module tb_conv_stream_tx;

    localparam int L     = 4;
    localparam int DEPTH = 16;
    localparam int WPF   = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic [31:0] i_data = '0;
    logic        tready = 1'b0;
    logic [31:0] tdata;
    logic        tvalid, tlast, ovf, fdone;
    logic [4:0]  fill;

    logic        i_valid0 = 1'b0;
    logic [31:0] i_data0 = '0;
    logic        tready0 = 1'b1;
    logic [31:0] tdata0;
    logic        tvalid0, tlast0, ovf0, fdone0;
    logic [4:0]  fill0;

    always #5 clk = ~clk;

    conv_stream_tx #(.NB_DATA(32), .CONV_LATENCY(L), .FIFO_DEPTH(DEPTH), .WORDS_PER_FRAME(WPF)) dut (
        .i_clk(clk), .i_reset(rst), .i_valid(i_valid), .i_data(i_data),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .m_axis_tlast(tlast), .o_overflow(ovf), .o_frame_done(fdone), .o_fill(fill)
    );

    conv_stream_tx #(.NB_DATA(32), .CONV_LATENCY(0), .FIFO_DEPTH(DEPTH), .WORDS_PER_FRAME(WPF)) dut0 (
        .i_clk(clk), .i_reset(rst), .i_valid(i_valid0), .i_data(i_data0),
        .m_axis_tdata(tdata0), .m_axis_tvalid(tvalid0), .m_axis_tready(tready0),
        .m_axis_tlast(tlast0), .o_overflow(ovf0), .o_frame_done(fdone0), .o_fill(fill0)
    );

    // Reference state: buffered words, valid history, frame position, flags.
    logic [31:0] mq[$];
    bit          vh[$];
    logic [32:0] dp[$];
    int          fcnt;
    bit          movf, mdone;

    int          vectors = 0;
    int          miscompares = 0;
    int          hs, fd_cnt;
    logic [31:0] tl_mask;
    bit          prev_stall;
    logic [31:0] prev_data;

    task automatic model_update();
        bit dv, rd;
        int sz;
        if (rst) begin
            mq.delete();
            vh.delete();
            for (int k = 0; k < L; k++) vh.push_back(1'b0);
            fcnt = 0; movf = 0; mdone = 0;
        end else begin
            sz = mq.size();
            dv = vh.pop_front();
            vh.push_back(i_valid);
            rd = (sz > 0) && tready;
            mdone = rd && (fcnt == WPF - 1);
            if (rd) begin
                void'(mq.pop_front());
                fcnt = (fcnt == WPF - 1) ? 0 : fcnt + 1;
            end
            if (dv) begin
                if (sz == DEPTH && !rd) movf = 1;
                else mq.push_back(i_data);
            end
        end
    endtask

    task automatic compare();
        bit ev, el, eo, edn;
        logic [31:0] ed;
        int ef;
        if (rst) begin
            ev = 0; el = 0; eo = 0; edn = 0; ed = '0; ef = 0;
        end else begin
            ev = mq.size() > 0;
            ed = ev ? mq[0] : '0;
            el = ev && (fcnt == WPF - 1);
            ef = mq.size();
            eo = movf;
            edn = mdone;
        end
        vectors++;
        if (tvalid !== ev || ((ev || rst) && tdata !== ed) || tlast !== el ||
            int'(fill) != ef || ovf !== eo || fdone !== edn) begin
            miscompares++;
            $display("FAIL cycle_check t=%0t got v=%b d=%h l=%b fill=%0d ovf=%b done=%b want v=%b d=%h l=%b fill=%0d ovf=%b done=%b",
                     $time, tvalid, tdata, tlast, fill, ovf, fdone, ev, ed, el, ef, eo, edn);
        end
        if (prev_stall && !rst) begin
            vectors++;
            if (tvalid !== 1'b1 || tdata !== prev_data) begin
                miscompares++;
                $display("FAIL stall_hold t=%0t got v=%b d=%h want v=1 d=%h", $time, tvalid, tdata, prev_data);
            end
        end
        if (!rst && tvalid && tready) begin
            hs++;
            if (tlast && hs < 32) tl_mask[hs] = 1'b1;
        end
        if (fdone) fd_cnt++;
        prev_stall = tvalid && !tready && !rst;
        prev_data  = tdata;
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic r, input logic rs);
        logic [32:0] e;
        @(posedge clk);
        model_update();
        #2;
        rst     = rs;
        i_valid = v;
        e       = dp.pop_front();
        dp.push_back({v, d});
        i_data  = e[32] ? e[31:0] : 32'hDEAD_BEEF;
        tready  = r;
        @(negedge clk);
        compare();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic clr_counts();
        hs = 0; fd_cnt = 0; tl_mask = '0;
    endtask

    task automatic do_reset();
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        clr_counts();
    endtask

    logic [31:0] pat;

    initial begin
        for (int k = 0; k < L; k++) dp.push_back('0);
        prev_stall = 0; prev_data = '0;
        clr_counts();
        pat = 32'h6D5A_B3C6;

        // Reset values
        do_reset();
        chk("rst_tvalid", 32'(tvalid), 32'd0);
        chk("rst_tdata", tdata, 32'd0);
        chk("rst_tlast", 32'(tlast), 32'd0);
        chk("rst_fill", 32'(fill), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_done", 32'(fdone), 32'd0);
        chk("rst0_tvalid", 32'(tvalid0), 32'd0);
        chk("rst0_fill", 32'(fill0), 32'd0);

        // 1: eight words with ready held high
        for (int i = 0; i < 16; i++) begin
            step(i < 8, 32'h0302_0100 + 32'(i), 1'b1, 1'b0);
            if (i == 4)  chk("t1_no_early", 32'(tvalid), 32'd0);
            if (i == 5)  chk("t1_first_word", tdata, 32'h0302_0100);
            if (i == 5)  chk("t1_first_valid", 32'(tvalid), 32'd1);
            if (i == 9)  chk("t1_tlast_word5", 32'(tlast), 32'd1);
            if (i == 12) chk("t1_last_word", tdata, 32'h0302_0107);
            if (i == 13) chk("t1_valid_drop", 32'(tvalid), 32'd0);
        end
        chk("t1_hs", 32'(hs), 32'd8);
        chk("t1_ovf", 32'(ovf), 32'd0);

        // 2: overflow with ready low, then drain
        do_reset();
        for (int i = 0; i < 17; i++) step(1'b1, 32'h2000_0000 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)  step(1'b0, '0, 1'b0, 1'b0);
        chk("t2_fill_full", 32'(fill), 32'd16);
        chk("t2_ovf_set", 32'(ovf), 32'd1);
        chk("t2_head", tdata, 32'h2000_0000);
        for (int i = 0; i < 24; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk("t2_drained", 32'(hs), 32'd16);
        chk("t2_ovf_sticky", 32'(ovf), 32'd1);
        chk("t2_fill_empty", 32'(fill), 32'd0);

        // 3: full buffer with simultaneous read and write
        do_reset();
        for (int i = 0; i < 50; i++) begin
            step(i < 26, 32'h3000_0000 + 32'(i), i >= 20, 1'b0);
            if (i == 20) chk("t3_fill_full", 32'(fill), 32'd16);
            if (i == 30) chk("t3_fill_held", 32'(fill), 32'd16);
        end
        chk("t3_ovf_clear", 32'(ovf), 32'd0);
        chk("t3_no_loss", 32'(hs), 32'd26);

        // 4: framing under irregular backpressure
        do_reset();
        for (int i = 0; i < 40; i++) step(i < 10, 32'h4000_0000 + 32'(i), (i < 25) ? pat[i] : 1'b1, 1'b0);
        chk("t4_hs", 32'(hs), 32'd10);
        chk("t4_tlast_pos", tl_mask, 32'h0000_0420);
        chk("t4_done_pulses", 32'(fd_cnt), 32'd2);

        // 5: reset mid-frame with words buffered
        do_reset();
        for (int i = 0; i < 10; i++) step(i < 5, 32'h5000_0000 + 32'(i), (i >= 5) && (i <= 7), 1'b0);
        chk("t5_sent", 32'(hs), 32'd3);
        chk("t5_fill2", 32'(fill), 32'd2);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("t5_rst_tvalid", 32'(tvalid), 32'd0);
        chk("t5_rst_fill", 32'(fill), 32'd0);
        step(1'b0, '0, 1'b0, 1'b0);
        clr_counts();
        for (int i = 0; i < 15; i++) step(i < 5, 32'h5100_0000 + 32'(i), 1'b1, 1'b0);
        chk("t5_new_frame_hs", 32'(hs), 32'd5);
        chk("t5_new_frame_tlast", tl_mask, 32'h0000_0020);

        // 6: zero-latency build
        i_valid0 = 1'b1;
        i_data0  = 32'hA5A5_5A5A;
        chk("t6_idle", 32'(tvalid0), 32'd0);
        step(1'b0, '0, 1'b1, 1'b0);
        i_valid0 = 1'b0;
        chk("t6_valid", 32'(tvalid0), 32'd1);
        chk("t6_data", tdata0, 32'hA5A5_5A5A);
        chk("t6_fill", 32'(fill0), 32'd1);
        chk("t6_tlast", 32'(tlast0), 32'd0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("t6_popped", 32'(tvalid0), 32'd0);
        chk("t6_ovf", 32'(ovf0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
